// File: rtl/led_blink_driver.sv
// led_blink_driver: drives one LED through N on/off blinks on request,
// timed by an internal tick prescaler; mirrors a static level while idle.
module led_blink_driver #(
  parameter int unsigned TICK_PERIOD = 4_000_000,
  parameter int unsigned ON_TICKS    = 5,
  parameter int unsigned OFF_TICKS   = 5,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [CNT_W-1:0] count,
  input  logic             level,
  output logic             ready,
  output logic             done,
  output logic             led
);

  localparam int unsigned PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  localparam logic [31:0]      TICK_LAST = 32'(TICK_PERIOD - 1);
  localparam logic [PH_W-1:0]  ON_LD     = PH_W'(ON_TICKS);
  localparam logic [PH_W-1:0]  OFF_LD    = PH_W'(OFF_TICKS);
  localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_ZERO = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      presc_q, presc_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             led_q, led_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             tick_s;

  // A tick is the last clock of each prescaler period.
  assign tick_s = (presc_q == TICK_LAST);

  assign ready = ready_q;
  assign done  = done_q;
  assign led   = led_q;

  // Next-state, counter and output decode for the blink sequencer.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    led_d    = led_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (count != '0) begin
            remain_d = count;
            presc_d  = 32'd0;
            phase_d  = ON_LD;
            led_d    = 1'b1;
            state_d  = S_ON;
          end else begin
            // Zero-length request: acknowledge only, LED untouched.
            state_d = S_ZERO;
          end
        end else begin
          led_d = level;
        end
      end

      S_ON: begin
        presc_d = tick_s ? 32'd0 : presc_q + 32'd1;
        if (tick_s) begin
          if (phase_q == PH_ONE) begin
            phase_d = OFF_LD;
            led_d   = 1'b0;
            state_d = S_OFF;
          end else begin
            phase_d = phase_q - PH_ONE;
          end
        end else begin
          led_d = 1'b1;
        end
      end

      S_OFF: begin
        presc_d = tick_s ? 32'd0 : presc_q + 32'd1;
        if (tick_s) begin
          if (phase_q == PH_ONE) begin
            remain_d = remain_q - CNT_ONE;
            if (remain_q == CNT_ONE) begin
              // Last blink finished; LED stays low this cycle, level next.
              phase_d = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              phase_d = ON_LD;
              led_d   = 1'b1;
              state_d = S_ON;
            end
          end else begin
            phase_d = phase_q - PH_ONE;
          end
        end else begin
          led_d = 1'b0;
        end
      end

      S_ZERO: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State, counters and registered outputs; rst wins over any accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      presc_q  <= 32'd0;
      phase_q  <= '0;
      remain_q <= '0;
      led_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      led_q    <= led_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_led_blink_driver.sv
// Self-checking bench for led_blink_driver: a timeline model computes the
// expected LED/ready/done from elapsed edges since accept; directed
// scenarios plus a randomized phase, with a few literal pins.
module tb_led_blink_driver;

  localparam int unsigned TP    = 4;
  localparam int unsigned ONT   = 2;
  localparam int unsigned OFFT  = 3;
  localparam int unsigned CW    = 4;
  localparam int          BLINK = (ONT + OFFT) * TP;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [CW-1:0] count;
  logic          level;
  logic          ready;
  logic          done;
  logic          led;

  int n_cmp = 0;
  int n_bad = 0;

  led_blink_driver #(
    .TICK_PERIOD(TP),
    .ON_TICKS   (ONT),
    .OFF_TICKS  (OFFT),
    .CNT_W      (CW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .count(count),
    .level(level),
    .ready(ready),
    .done (done),
    .led  (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- timeline reference model ----------------
  int   cyc = 0;
  bit   m_valid = 0;
  bit   m_busy = 0;
  int   m_start = 0;
  int   m_n = 0;
  logic exp_led, exp_rdy, exp_done;

  always @(posedge clk) begin
    int k;
    int total;
    cyc++;
    if (rst) begin
      m_valid  = 1;
      m_busy   = 0;
      exp_led  = 1'b0;
      exp_rdy  = 1'b1;
      exp_done = 1'b0;
    end else if (m_valid) begin
      exp_done = 1'b0;
      if (m_busy) begin
        k     = cyc - m_start;
        total = (m_n == 0) ? 1 : m_n * BLINK;
        if (k >= total) begin
          exp_rdy  = 1'b1;
          exp_done = 1'b1;
          m_busy   = 0;
          if (m_n != 0) exp_led = 1'b0;
        end else begin
          exp_rdy = 1'b0;
          if (m_n != 0) exp_led = ((k % BLINK) < ONT * TP);
        end
      end else if (req) begin
        m_busy  = 1;
        m_start = cyc;
        m_n     = count;
        exp_rdy = 1'b0;
        if (count != 0) exp_led = 1'b1;
      end else begin
        exp_led = level;
        exp_rdy = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("led",   {31'd0, led},   {31'd0, exp_led});
      chk("ready", {31'd0, ready}, {31'd0, exp_rdy});
      chk("done",  {31'd0, done},  {31'd0, exp_done});
    end
  end

  // Issue one request from idle and tally outputs over the whole transfer.
  task automatic run_blink(input int n, input bit noise,
                           output int low_c, output int high_c, output int done_c);
    int len;
    low_c = 0; high_c = 0; done_c = 0;
    len = (n == 0) ? 5 : n * BLINK + 5;
    req   = 1'b1;
    count = CW'(n);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (ready === 1'b0) low_c++;
      if (led === 1'b1)   high_c++;
      if (done === 1'b1)  done_c++;
      if (noise && (i == 10 || i == 30)) begin
        req = 1'b1; count = CW'(5);
      end else begin
        req = 1'b0; count = CW'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin
    int lo, hi, dn;
    int a0;
    int dq[$];

    rst = 1'b1; req = 1'b0; count = '0; level = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_led",   {31'd0, led},   32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done",  {31'd0, done},  32'd0);
    rst = 1'b0; level = 1'b1;
    @(negedge clk);
    chk("level_follow", {31'd0, led}, 32'd1);
    level = 1'b0;
    @(negedge clk);

    // count=3 clean transfer
    run_blink(3, 1'b0, lo, hi, dn);
    chk("c3_ready_low", lo, 32'd60);
    chk("c3_led_high",  hi, 32'd24);
    chk("c3_done",      dn, 32'd1);

    // count=0
    run_blink(0, 1'b0, lo, hi, dn);
    chk("c0_ready_low", lo, 32'd1);
    chk("c0_led_high",  hi, 32'd0);
    chk("c0_done",      dn, 32'd1);

    // count=3 with ignored requests mid-transfer
    run_blink(3, 1'b1, lo, hi, dn);
    chk("noise_ready_low", lo, 32'd60);
    chk("noise_led_high",  hi, 32'd24);
    chk("noise_done",      dn, 32'd1);

    // reset in the middle of an ON phase
    req = 1'b1; count = CW'(3);
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_led",   {31'd0, led},   32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    chk("mid_rst_done",  {31'd0, done},  32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_blink(1, 1'b0, lo, hi, dn);
    chk("after_rst_ready_low", lo, 32'd20);
    chk("after_rst_led_high",  hi, 32'd8);
    chk("after_rst_done",      dn, 32'd1);

    // back-to-back with req held high
    a0 = cyc + 1;
    req = 1'b1; count = CW'(1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) dq.push_back(cyc - a0);
    end
    req = 1'b0;
    chk("b2b_done_cnt", dq.size(), 32'd2);
    if (dq.size() >= 2) begin
      chk("b2b_done0", dq[0], 32'd20);
      chk("b2b_done1", dq[1], 32'd41);
    end
    repeat (3) @(negedge clk);

    // randomized traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      req   = ($urandom_range(0, 7) == 0);
      count = CW'($urandom_range(0, 3));
      level = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0; req = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
